// File: rtl/spi_reg_bridge_pkg.sv
// ---------------------------------------------------------------------------
// spi_bridge_pkg
//
// Shared definitions for the SPI-to-register-bus bridge:
//   bridge_state_t : the five frame-decoding states
//   CMD_RNW_BIT    : command byte bit selecting read (1) or write (0)
//   CMD_FIX_BIT    : command byte bit that freezes the register address
//   TX_IDLE        : byte presented on tx_byte whenever no read data is due
// ---------------------------------------------------------------------------
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_RD_REQ,
        ST_RD_WAIT
    } bridge_state_t;

    localparam int CMD_RNW_BIT = 7;
    localparam int CMD_FIX_BIT = 6;

    localparam logic [7:0] TX_IDLE = 8'h00;

endpackage

// File: rtl/spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge
//
// Decodes SPI frames of the form  command, address bytes, data words  and
// turns them into register-bus writes and reads. Write words are assembled
// MSB first and committed with a one-cycle reg_we; read words are fetched
// with a one-cycle reg_re and serialised MSB first onto tx_byte. Reads
// always prefetch the word following the one being clocked out.
//
// Parameters
//   ADDR_W    : register address width, multiple of 8 (8 or 16)
//   DATA_W    : register word width, multiple of 8 (8, 16 or 32)
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   cs_n      : synchronised SPI chip select, high = bus idle
//   rx_byte   : byte received from spi_slave
//   rx_valid  : one-cycle strobe qualifying rx_byte
//   tx_byte   : byte spi_slave shifts out on the next SPI byte
//   reg_addr  : register address
//   reg_wdata : register write word
//   reg_we    : one-cycle write strobe
//   reg_re    : one-cycle read strobe
//   reg_rdata : read word, valid the cycle after reg_re
//   overrun   : sticky, a byte arrived while a read fetch was outstanding
// ---------------------------------------------------------------------------
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              overrun
);

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int AC_W       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int DC_W       = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [AC_W-1:0]   ADDR_LAST = AC_W'(ADDR_BYTES - 1);
    localparam logic [DC_W-1:0]   DATA_LAST = DC_W'(DATA_BYTES - 1);
    localparam logic [DATA_W-1:0] TX_CLEAR  = DATA_W'(TX_IDLE) << (DATA_W - 8);

    bridge_state_t     state_q, state_d;
    logic              rnw_q, rnw_d;
    logic              fix_q, fix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [AC_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [DC_W-1:0]   data_cnt_q, data_cnt_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              overrun_q, overrun_d;
    logic              cs_n_prev_q;

    logic addr_last;
    logic data_last;

    assign addr_last = (addr_cnt_q == ADDR_LAST);
    assign data_last = (data_cnt_q == DATA_LAST);

    // Next-state logic. Chip select high overrides everything so that an
    // aborted frame leaves no half-built word or pending fetch behind.
    always_comb begin
        state_d    = state_q;
        rnw_d      = rnw_q;
        fix_d      = fix_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_shift_d = tx_shift_q;
        addr_cnt_d = addr_cnt_q;
        data_cnt_d = data_cnt_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        overrun_d  = overrun_q;

        // Overrun is cleared only when a new frame starts.
        if (cs_n_prev_q && !cs_n) begin
            overrun_d = 1'b0;
        end

        if (cs_n) begin
            state_d    = ST_CMD;
            addr_cnt_d = '0;
            data_cnt_d = '0;
            tx_shift_d = TX_CLEAR;
        end else begin
            // The address steps in the cycle after a write pulse, so the
            // pulse itself sees a stable address.
            if (we_q && !fix_q) begin
                addr_d = addr_q + ADDR_W'(1);
            end

            unique case (state_q)
                ST_CMD: begin
                    tx_shift_d = TX_CLEAR;
                    if (rx_valid) begin
                        rnw_d      = rx_byte[CMD_RNW_BIT];
                        fix_d      = rx_byte[CMD_FIX_BIT];
                        addr_cnt_d = '0;
                        data_cnt_d = '0;
                        state_d    = ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_d = (addr_q << 8) | ADDR_W'(rx_byte);
                        if (addr_last) begin
                            data_cnt_d = '0;
                            if (rnw_q) begin
                                re_d    = 1'b1;
                                state_d = ST_RD_REQ;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else begin
                            addr_cnt_d = addr_cnt_q + AC_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        if (rnw_q) begin
                            // Word fully clocked out: step and prefetch.
                            if (data_last) begin
                                if (!fix_q) begin
                                    addr_d = addr_q + ADDR_W'(1);
                                end
                                re_d       = 1'b1;
                                data_cnt_d = '0;
                                state_d    = ST_RD_REQ;
                            end else begin
                                tx_shift_d = tx_shift_q << 8;
                                data_cnt_d = data_cnt_q + DC_W'(1);
                            end
                        end else begin
                            wdata_d = (wdata_q << 8) | DATA_W'(rx_byte);
                            if (data_last) begin
                                we_d       = 1'b1;
                                data_cnt_d = '0;
                            end else begin
                                data_cnt_d = data_cnt_q + DC_W'(1);
                            end
                        end
                    end
                end

                ST_RD_REQ: begin
                    state_d = ST_RD_WAIT;
                    if (rx_valid) begin
                        overrun_d  = 1'b1;
                        data_cnt_d = data_last ? '0 : data_cnt_q + DC_W'(1);
                    end
                end

                ST_RD_WAIT: begin
                    tx_shift_d = reg_rdata;
                    state_d    = ST_DATA;
                    if (rx_valid) begin
                        overrun_d  = 1'b1;
                        data_cnt_d = data_last ? '0 : data_cnt_q + DC_W'(1);
                    end
                end

                default: begin
                    state_d = ST_CMD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CMD;
            rnw_q       <= 1'b0;
            fix_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tx_shift_q  <= TX_CLEAR;
            addr_cnt_q  <= '0;
            data_cnt_q  <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            overrun_q   <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            fix_q       <= fix_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_shift_q  <= tx_shift_d;
            addr_cnt_q  <= addr_cnt_d;
            data_cnt_q  <= data_cnt_d;
            we_q        <= we_d;
            re_q        <= re_d;
            overrun_q   <= overrun_d;
            cs_n_prev_q <= cs_n;
        end
    end

    assign tx_byte   = tx_shift_q[DATA_W-1 -: 8];
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bridge
//
// Bench for spi_reg_bridge. Instance A (ADDR_W=8, DATA_W=16) takes directed
// and random frames; a reference model derived from the frame rules pushes
// the expected register-bus events into a queue which a negedge monitor
// drains. Instance B (ADDR_W=8, DATA_W=32) covers the wide read path and the
// sticky overrun flag.
// ---------------------------------------------------------------------------
module tb_spi_reg_bridge;

    typedef struct packed {
        logic        isWrite;
        logic [7:0]  addr;
        logic [15:0] data;
    } sbEvent_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        cs_n_a;
    logic [7:0]  rx_byte_a;
    logic        rx_valid_a;
    logic [7:0]  tx_byte_a;
    logic [7:0]  reg_addr_a;
    logic [15:0] reg_wdata_a;
    logic        reg_we_a;
    logic        reg_re_a;
    logic [15:0] reg_rdata_a = '0;
    logic        overrun_a;

    logic        cs_n_b;
    logic [7:0]  rx_byte_b;
    logic        rx_valid_b;
    logic [7:0]  tx_byte_b;
    logic [7:0]  reg_addr_b;
    logic [31:0] reg_wdata_b;
    logic        reg_we_b;
    logic        reg_re_b;
    logic [31:0] reg_rdata_b = '0;
    logic        overrun_b;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [15:0] salt = 16'h0000;
    logic [7:0]  frame[$];
    logic [7:0]  txExp[$];
    sbEvent_t    expQ[$];

    int         reCountB    = 0;
    logic [7:0] lastReAddrB = 8'h00;

    always #5 clk = ~clk;

    spi_reg_bridge #(.ADDR_W(8), .DATA_W(16)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n_a),
        .rx_byte   (rx_byte_a),
        .rx_valid  (rx_valid_a),
        .tx_byte   (tx_byte_a),
        .reg_addr  (reg_addr_a),
        .reg_wdata (reg_wdata_a),
        .reg_we    (reg_we_a),
        .reg_re    (reg_re_a),
        .reg_rdata (reg_rdata_a),
        .overrun   (overrun_a)
    );

    spi_reg_bridge #(.ADDR_W(8), .DATA_W(32)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n_b),
        .rx_byte   (rx_byte_b),
        .rx_valid  (rx_valid_b),
        .tx_byte   (tx_byte_b),
        .reg_addr  (reg_addr_b),
        .reg_wdata (reg_wdata_b),
        .reg_we    (reg_we_b),
        .reg_re    (reg_re_b),
        .reg_rdata (reg_rdata_b),
        .overrun   (overrun_b)
    );

    // Register file contents as seen by the bridges.
    function automatic logic [15:0] modelWord(input logic [7:0] a);
        return (16'(a) * 16'h0101) ^ salt;
    endfunction

    function automatic logic [31:0] modelWordB(input logic [7:0] a);
        return {a, ~a, a ^ 8'h3C, 8'hA5};
    endfunction

    // Register files answer one cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_re_a) reg_rdata_a <= modelWord(reg_addr_a);
        if (reg_re_b) reg_rdata_b <= modelWordB(reg_addr_b);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every bus strobe on instance A must match the next event the
    // model predicted.
    always @(negedge clk) begin
        if (rst_n && (reg_we_a || reg_re_a)) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_strobe", {30'd0, reg_we_a, reg_re_a}, 32'd0);
            end else begin
                sbEvent_t ev;
                ev = expQ.pop_front();
                checkOutput("sb_kind_we", 32'(reg_we_a), 32'(ev.isWrite));
                checkOutput("sb_kind_re", 32'(reg_re_a), 32'(!ev.isWrite));
                checkOutput("sb_addr", 32'(reg_addr_a), 32'(ev.addr));
                if (ev.isWrite) checkOutput("sb_wdata", 32'(reg_wdata_a), 32'(ev.data));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && reg_re_b) begin
            reCountB    <= reCountB + 1;
            lastReAddrB <= reg_addr_b;
        end
    end

    // Reference model: from the frame bytes alone, predict the bus events and
    // the tx byte expected before each byte of the frame.
    task automatic modelFrame();
        logic        rnw, fix;
        logic [7:0]  base, step;
        logic [15:0] word;
        int          nd;
        sbEvent_t    ev;
        txExp.delete();
        for (int i = 0; i < frame.size(); i++) txExp.push_back(8'h00);
        if (frame.size() < 2) return;
        rnw  = frame[0][7];
        fix  = frame[0][6];
        base = frame[1];
        step = fix ? 8'd0 : 8'd1;
        nd   = frame.size() - 2;
        if (rnw) begin
            for (int r = 0; r <= nd / 2; r++) begin
                ev.isWrite = 1'b0;
                ev.addr    = base + step * 8'(r);
                ev.data    = 16'h0000;
                expQ.push_back(ev);
            end
            for (int j = 0; j < nd; j++) begin
                word = modelWord(base + step * 8'(j / 2));
                txExp[2 + j] = (j % 2 == 0) ? word[15:8] : word[7:0];
            end
        end else begin
            for (int w = 0; w < nd / 2; w++) begin
                ev.isWrite = 1'b1;
                ev.addr    = base + step * 8'(w);
                ev.data    = {frame[2 + 2 * w], frame[3 + 2 * w]};
                expQ.push_back(ev);
            end
        end
    endtask

    // Drive one frame into instance A with generous inter-byte gaps, checking
    // tx_byte ahead of each byte.
    task automatic applyStimulus();
        modelFrame();
        @(posedge clk); #1;
        cs_n_a = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < frame.size(); i++) begin
            #1;
            checkOutput($sformatf("tx_byte[%0d]", i), 32'(tx_byte_a), 32'(txExp[i]));
            rx_byte_a  = frame[i];
            rx_valid_a = 1'b1;
            @(posedge clk); #1;
            rx_valid_a = 1'b0;
            repeat (6) @(posedge clk);
        end
        repeat (3) @(posedge clk); #1;
        cs_n_a = 1'b1;
        repeat (3) @(posedge clk); #1;
        checkOutput("overrun_a_idle", 32'(overrun_a), 32'd0);
        checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
        checkOutput("tx_idle_after_frame", 32'(tx_byte_a), 32'd0);
    endtask

    task automatic sendByteB(input logic [7:0] b);
        #1;
        rx_byte_b  = b;
        rx_valid_b = 1'b1;
        @(posedge clk); #1;
        rx_valid_b = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] wordB;
        sbEvent_t    ev;

        rst_n      = 1'b0;
        cs_n_a     = 1'b1;
        rx_byte_a  = 8'h00;
        rx_valid_a = 1'b0;
        cs_n_b     = 1'b1;
        rx_byte_b  = 8'h00;
        rx_valid_b = 1'b0;

        repeat (3) @(posedge clk); #1;
        checkOutput("rst_tx_a", 32'(tx_byte_a), 32'd0);
        checkOutput("rst_addr_a", 32'(reg_addr_a), 32'd0);
        checkOutput("rst_wdata_a", 32'(reg_wdata_a), 32'd0);
        checkOutput("rst_we_a", 32'(reg_we_a), 32'd0);
        checkOutput("rst_re_a", 32'(reg_re_a), 32'd0);
        checkOutput("rst_overrun_a", 32'(overrun_a), 32'd0);
        checkOutput("rst_tx_b", 32'(tx_byte_b), 32'd0);
        checkOutput("rst_wdata_b", reg_wdata_b, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] directed frames on 8/16 instance");
        frame = '{8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78};
        applyStimulus();
        frame = '{8'h40, 8'h20, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        applyStimulus();
        salt  = 16'h0000;
        frame = '{8'h80, 8'h05, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        applyStimulus();
        frame = '{8'h00, 8'h30, 8'h99};
        applyStimulus();
        frame = '{8'h00, 8'h31, 8'h11, 8'h22};
        applyStimulus();
        frame = '{8'h00, 8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        applyStimulus();
        frame = '{8'hC0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus();
        frame = '{8'h80, 8'hFF, 8'h00, 8'h00, 8'h00};
        applyStimulus();

        $display("[TB] random frames on 8/16 instance");
        for (int f = 0; f < 40; f++) begin
            frame.delete();
            salt = 16'($urandom);
            frame.push_back({2'($urandom), 6'($urandom)});
            frame.push_back(8'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 6)); k++) frame.push_back(8'($urandom));
            applyStimulus();
        end

        $display("[TB] reset while a read fetch is outstanding");
        salt       = 16'h0000;
        ev.isWrite = 1'b0;
        ev.addr    = 8'h05;
        ev.data    = 16'h0000;
        expQ.push_back(ev);
        @(posedge clk); #1;
        cs_n_a = 1'b0;
        repeat (3) @(posedge clk); #1;
        rx_byte_a  = 8'h80;
        rx_valid_a = 1'b1;
        @(posedge clk); #1;
        rx_valid_a = 1'b0;
        repeat (6) @(posedge clk); #1;
        rx_byte_a  = 8'h05;
        rx_valid_a = 1'b1;
        @(posedge clk); #1;
        rx_valid_a = 1'b0;
        checkOutput("rd_re_at_n1", 32'(reg_re_a), 32'd1);
        @(posedge clk); #1;
        checkOutput("rd_re_low_n2", 32'(reg_re_a), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tx", 32'(tx_byte_a), 32'd0);
        checkOutput("async_rst_addr", 32'(reg_addr_a), 32'd0);
        checkOutput("async_rst_wdata", 32'(reg_wdata_a), 32'd0);
        checkOutput("async_rst_we", 32'(reg_we_a), 32'd0);
        checkOutput("async_rst_re", 32'(reg_re_a), 32'd0);
        checkOutput("async_rst_overrun", 32'(overrun_a), 32'd0);
        cs_n_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        checkOutput("sb_drain_reset", 32'(expQ.size()), 32'd0);

        $display("[TB] 8/32 instance read and overrun");
        @(posedge clk); #1;
        cs_n_b = 1'b0;
        repeat (3) @(posedge clk);
        sendByteB(8'h80);
        sendByteB(8'h07);
        wordB = modelWordB(8'h07);
        for (int j = 0; j < 4; j++) begin
            #1;
            checkOutput($sformatf("b_tx_byte[%0d]", j), 32'(tx_byte_b), 32'(wordB[31 - 8 * j -: 8]));
            sendByteB(8'h00);
        end
        #1;
        checkOutput("b_re_count", 32'(reCountB), 32'd2);
        checkOutput("b_last_re_addr", 32'(lastReAddrB), 32'h08);
        checkOutput("b_overrun_clean", 32'(overrun_b), 32'd0);
        cs_n_b = 1'b1;
        repeat (4) @(posedge clk); #1;

        cs_n_b = 1'b0;
        repeat (3) @(posedge clk);
        sendByteB(8'h80);
        #1;
        rx_byte_b  = 8'h07;
        rx_valid_b = 1'b1;
        @(posedge clk); #1;
        rx_valid_b = 1'b0;
        checkOutput("b_re_at_n1", 32'(reg_re_b), 32'd1);
        @(posedge clk); #1;
        rx_byte_b  = 8'h00;
        rx_valid_b = 1'b1;
        @(posedge clk); #1;
        rx_valid_b = 1'b0;
        checkOutput("b_overrun_set", 32'(overrun_b), 32'd1);
        repeat (6) @(posedge clk);
        sendByteB(8'h00);
        #1;
        checkOutput("b_overrun_sticky", 32'(overrun_b), 32'd1);
        cs_n_b = 1'b1;
        repeat (4) @(posedge clk); #1;
        checkOutput("b_overrun_cs_high", 32'(overrun_b), 32'd1);
        cs_n_b = 1'b0;
        repeat (2) @(posedge clk); #1;
        checkOutput("b_overrun_cleared", 32'(overrun_b), 32'd0);
        cs_n_b = 1'b1;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Parametrised SPI-to-register-bus bridge. It sits between `spi_slave` and the settings/register file, and replaces the fixed address-then-write-data state machine in the top level. It decodes a command byte carrying read/write and increment mode, then a multi-byte address. It moves multi-byte words in both directions: it assembles write words and pulses a write strobe, and it fetches read words and serialises them onto `tx_byte` for the next SPI bytes.

## Interface
- `ADDR_W`, 8: register address width in bits; multiple of 8 (8 or 16).
- `DATA_W`, 8: register word width in bits; multiple of 8 (8, 16 or 32).
- `clk` input 1: system clock (100 MHz domain).
- `rst_n` input 1: reset, asynchronous, active-low.
- `cs_n` input 1: SPI chip select, already synchronised to `clk`; high means the bus is idle.
- `rx_byte` input 8: received byte from `spi_slave`.
- `rx_valid` input 1: one-cycle strobe; `rx_byte` is valid in that cycle.
- `tx_byte` output 8: byte `spi_slave` shifts out on the next SPI byte.
- `reg_addr` output ADDR_W: register address.
- `reg_wdata` output DATA_W: write word.
- `reg_we` output 1: one-cycle write strobe.
- `reg_re` output 1: one-cycle read strobe.
- `reg_rdata` input DATA_W: read word, valid exactly 1 cycle after `reg_re`.
- `overrun` output 1: sticky flag; a byte arrived while a read fetch was pending.

## Operation
- Frame layout:
  - First byte is the command byte: bit 7 = RNW (1 = read), bit 6 = FIX (1 = no address increment), bits 5:0 ignored.
  - Next come ADDR_W/8 address bytes, MSB first.
  - Then data words of DATA_W/8 bytes each, MSB first.
- States: CMD, ADDR, DATA, RD_REQ, RD_WAIT.
- CMD to ADDR on `rx_valid`: latch RNW and FIX.
- ADDR: shift address bytes into `reg_addr`. On the last address byte, go to RD_REQ if RNW is set, otherwise DATA.
- DATA, write mode: shift bytes into `reg_wdata`. On the last byte of a word:
  - pulse `reg_we` for one cycle, with `reg_addr` and `reg_wdata` stable during the pulse;
  - in the cycle after the pulse, `reg_addr` advances by 1 unless FIX is set.
- DATA, read mode, on each `rx_valid`:
  - not the last byte of the word: shift the tx word so `tx_byte` becomes the next byte;
  - last byte of the word: advance the address (unless FIX) and go to RD_REQ, which prefetches the next word.
- RD_REQ: assert `reg_re`, then go to RD_WAIT.
- RD_WAIT: capture `reg_rdata` into the tx shift register, `tx_byte` takes the MSB byte, then go to DATA.
- Reads prefetch: the word after the last one clocked out is always read. Registers with read side effects must account for this.
- `tx_byte` is 8'h00 in CMD, ADDR and write-mode DATA.
- `reg_addr` wraps modulo 2^ADDR_W.
- `cs_n` high, in any state:
  - next state is CMD; byte counters clear;
  - a partially assembled write word is discarded and no `reg_we` is issued;
  - a pending RD_REQ is dropped;
  - `cs_n` high takes priority over a simultaneous `rx_valid`.
- `rx_valid` in RD_REQ or RD_WAIT:
  - set `overrun` and count the byte as a data byte;
  - `tx_byte` for that byte is undefined.
- `overrun` clears only on the `cs_n` falling edge or on reset.

## Timing
- Reset: state CMD; `tx_byte`, `reg_addr`, `reg_wdata`, `reg_we`, `reg_re` and `overrun` all 0.
- Write: `reg_we` is high in cycle N+1, where N is the `rx_valid` cycle of the word's last byte.
- Read fetch, measured from the final address byte's `rx_valid` at cycle N (or the last data byte of a word):
  - `reg_re` is high at N+1;
  - `reg_rdata` is sampled at N+2;
  - `tx_byte` is valid from N+3.
- Intra-word shift: `tx_byte` is updated at N+1.
- System requirement: the SPI master leaves at least 4 `clk` cycles between the end of one byte and the first SCLK edge of the next.
- All outputs are registered.

## Structure
- Package `spi_bridge_pkg` holds:
  - `bridge_state_t` (the five states);
  - the command bit positions `CMD_RNW_BIT = 7` and `CMD_FIX_BIT = 6`;
  - the idle tx value `TX_IDLE = 8'h00`.
- No sub-module. Byte counters are sized `$clog2` of ADDR_W/8 and DATA_W/8, minimum 1 bit.
- The top level instantiates `spi_slave`, then this block, then the settings controller.

## Test plan
1. ADDR_W=8, DATA_W=16. Bytes 00 10 12 34 56 78 -> `reg_we` at (0x10, 0x1234), then at (0x11, 0x5678).
2. Bytes 40 20 AB CD EF 01 -> two `reg_we` pulses, both at 0x20, with data 0xABCD then 0xEF01.
3. Register model returns addr×0x0101. Bytes 80 05 then 4 dummy bytes -> `tx_byte` sequence 05 05 06 06; `reg_re` at addresses 05, 06 and 07.
4. Bytes 00 30 99, then `cs_n` high -> no `reg_we`. A following frame 00 31 11 22 -> one write at (0x31, 0x1122).
5. Bytes 00 FF plus two words -> writes at 0xFF, then 0x00 (wrap).
6. `rst_n` low during RD_WAIT -> all outputs 0 immediately. With DATA_W=32, a byte inserted 1 cycle after a read strobe sets `overrun`, which stays set until the next `cs_n` fall.
